// File: rtl/buf_pkg.sv
// ============================================================================
// Module  : buf_pkg
// Purpose : Shared defaults and width helpers for the parametrised FIFO buffer.
//           DEF_* constants are the default geometry; ptr_w/cnt_w give the
//           pointer and occupancy widths for a given depth.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package buf_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_AF_LEVEL = 3;

  // Pointer width: enough bits to index DEPTH entries.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: must also represent the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/buf_ptr_ctr.sv
// ============================================================================
// Module  : buf_ptr_ctr
// Purpose : WIDTH-bit wrapping pointer counter. A synchronous clear has
//           priority over increment; rst clears asynchronously.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-high reset
//           clr  - synchronous clear to 0
//           inc  - advance by one, wrapping 2**WIDTH-1 -> 0
//           ptr  - current pointer value
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module buf_ptr_ctr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  // DEPTH is a power of two, so the natural binary rollover is the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/param_fifo_buffer.sv
// ============================================================================
// Module  : param_fifo_buffer
// Purpose : DEPTH-entry first-word-fall-through FIFO with valid/ready on both
//           sides, registered occupancy/status flags and a synchronous flush.
//           Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
//           error outputs.
// Ports   : clk, rst (async, active-high), flush (sync discard)
//           wr_valid/wr_ready/wr_data  - producer side
//           rd_valid/rd_ready/rd_data  - consumer side
//           count, full, empty, almost_full - status
//           err_ovf, err_udf           - only with FIFO_ERR_FLAGS_EN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module param_fifo_buffer
  import buf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                     err_ovf,
  output logic                     err_udf
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic [CW-1:0]     cnt_next;

  // Handshake qualification. wr_ready is deliberately independent of
  // rd_ready: a full buffer refuses a write even when a pop is in flight.
  assign wr_ready = ~full;
  assign rd_valid = ~empty;
  assign push     = wr_valid & ~full;
  assign pop      = rd_ready & ~empty;

  buf_ptr_ctr #(.WIDTH(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  buf_ptr_ctr #(.WIDTH(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Storage resets to zero so unwritten entries never present X on rd_data.
  // Flush leaves contents untouched; only the pointers and count move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

  always_comb begin
    cnt_next = count;
    if (push && !pop) begin
      cnt_next = count + CW'(1);
    end else if (pop && !push) begin
      cnt_next = count - CW'(1);
    end
  end

  // Flags are derived from the next count so they change on the same edge
  // as count itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else if (flush) begin
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      count       <= cnt_next;
      empty       <= (cnt_next == '0);
      full        <= (cnt_next == CW'(DEPTH));
      almost_full <= (cnt_next >= CW'(AF_LEVEL));
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error indicators; flush clears them even if an error condition
  // is present in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else if (flush) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (wr_valid && full) begin
        err_ovf <= 1'b1;
      end
      if (rd_ready && empty) begin
        err_udf <= 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_fifo_buffer.sv
// ============================================================================
// Module  : tb_param_fifo_buffer
// Purpose : Self-checking bench for param_fifo_buffer (DATA_W=8, DEPTH=4,
//           AF_LEVEL=3). A queue-based reference model tracks contents and
//           status; directed scenarios are followed by random traffic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_fifo_buffer;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        count;
  logic              full;
  logic              empty;
  logic              almost_full;
`ifdef FIFO_ERR_FLAGS_EN
  logic              err_ovf;
  logic              err_udf;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  bit                m_ovf;
  bit                m_udf;

  always #5 clk = ~clk;

  param_fifo_buffer #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .err_ovf     (err_ovf),
    .err_udf     (err_udf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    int sz;
    sz = q.size();
    check("count",       32'(count),       32'(sz));
    check("empty",       32'(empty),       32'(sz == 0));
    check("full",        32'(full),        32'(sz == DEPTH));
    check("almost_full", 32'(almost_full), 32'(sz >= AF_LEVEL));
    check("wr_ready",    32'(wr_ready),    32'(sz != DEPTH));
    check("rd_valid",    32'(rd_valid),    32'(sz != 0));
    if (sz != 0) check("rd_data", 32'(rd_data), 32'(q[0]));
`ifdef FIFO_ERR_FLAGS_EN
    check("err_ovf", 32'(err_ovf), 32'(m_ovf));
    check("err_udf", 32'(err_udf), 32'(m_udf));
`endif
  endtask

  // Apply one cycle of inputs, advance model, check after the edge.
  task automatic cycle(input bit f, input bit wv, input logic [DATA_W-1:0] wd, input bit rr);
    bit was_full, was_empty;
    flush    = f;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wv && was_full)  m_ovf = 1'b1;
      if (rr && was_empty) m_udf = 1'b1;
      if (rr && !was_empty) void'(q.pop_front());
      if (wv && !was_full)  q.push_back(wd);
    end
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    compare_all();
  endtask

  task automatic drain();
    while (q.size() != 0) cycle(0, 0, 8'h00, 1);
  endtask

  initial begin : main
    logic [DATA_W-1:0] exp_seq [6];
    int idx;
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0;
    #12;
    compare_all();
    check("reset rd_data", 32'(rd_data), 32'h0);
    rst = 1'b0;

    // T1: async reset mid-stream with two entries stored
    cycle(0, 1, 8'hC1, 0);
    cycle(0, 1, 8'hC2, 0);
    check("T1 pre count", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    q.delete();
    check("T1 count",    32'(count),    32'd0);
    check("T1 empty",    32'(empty),    32'd1);
    check("T1 rd_valid", 32'(rd_valid), 32'd0);
    check("T1 rd_data",  32'(rd_data),  32'h0);
    check("T1 full",     32'(full),     32'd0);
    #2 rst = 1'b0;

    // T2: ordering and pointer wrap
    cycle(0, 1, 8'h11, 0);
    cycle(0, 1, 8'h22, 0);
    cycle(0, 1, 8'h33, 0);
    cycle(0, 1, 8'h44, 0);
    check("T2 full",     32'(full),     32'd1);
    check("T2 wr_ready", 32'(wr_ready), 32'd0);
    idx = 0;
    for (int i = 0; i < 2; i++) begin
      check("T2 rd_seq", 32'(rd_data), 32'(exp_seq[idx])); idx++;
      cycle(0, 0, 8'h00, 1);
    end
    cycle(0, 1, 8'h55, 0);
    cycle(0, 1, 8'h66, 0);
    for (int i = 0; i < 4; i++) begin
      check("T2 rd_seq", 32'(rd_data), 32'(exp_seq[idx])); idx++;
      cycle(0, 0, 8'h00, 1);
    end
    check("T2 empty", 32'(empty), 32'd1);

    // T3: full buffer refuses a write even with a concurrent pop
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'(8'h30 + i), 0);
    cycle(0, 1, 8'h99, 1);
    check("T3 count", 32'(count), 32'd3);
    cycle(0, 1, 8'h77, 0);
    check("T3 accept", 32'(count), 32'd4);
    drain();

    // T4: concurrent push/pop keeps occupancy
    cycle(0, 1, 8'h01, 0);
    cycle(0, 1, 8'h02, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 8'hA5, 1);
      check("T4 count", 32'(count),       32'd2);
      check("T4 af",    32'(almost_full), 32'd0);
    end
    drain();

    // T5: flush overrides concurrent push and pop
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'(8'h50 + i), 0);
    cycle(1, 1, 8'hEE, 1);
    check("T5 count",    32'(count),    32'd0);
    check("T5 empty",    32'(empty),    32'd1);
    check("T5 rd_valid", 32'(rd_valid), 32'd0);
    cycle(0, 0, 8'h00, 0);
    check("T5 discard", 32'(count), 32'd0);

`ifdef FIFO_ERR_FLAGS_EN
    // T6: sticky error flags
    cycle(0, 0, 8'h00, 1);
    check("T6 udf", 32'(err_udf), 32'd1);
    cycle(0, 0, 8'h00, 0);
    check("T6 udf held", 32'(err_udf), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'(8'h60 + i), 0);
    cycle(0, 1, 8'hBB, 0);
    check("T6 ovf", 32'(err_ovf), 32'd1);
    cycle(0, 0, 8'h00, 0);
    check("T6 ovf held", 32'(err_ovf), 32'd1);
    cycle(1, 0, 8'h00, 0);
    check("T6 ovf clr", 32'(err_ovf), 32'd0);
    check("T6 udf clr", 32'(err_udf), 32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 1)),
            8'($urandom),
            1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
